frame_sequencer: RTL
====================

# frame_sequencer

APU frame sequencer that divides `apu_clk` into the quarter-frame and half-frame events used by the pulse channels. These events drive the envelope, length counter and sweep units. It owns the frame-counter control register (sequence mode, IRQ inhibit) and raises the frame interrupt at the end of a 4-step sequence. One instance sits at APU top level and fans `qtr_pulse`/`hlf_pulse` out to every channel.

## Interface
- `STEP`, default 3729: `apu_clk` cycles per sequencer step; legal range 2..65535.
- `apu_clk`  in  1  APU clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  one-cycle write strobe for the frame-counter register.
- `wr_data`  in  8  write data:
  - bit7 = mode (0 = 4-step, 1 = 5-step).
  - bit6 = IRQ inhibit.
  - bits5:0 are ignored.
- `irq_ack`  in  1  one-cycle status-read strobe; clears `frame_irq`.
- `qtr_pulse`  out  1  quarter-frame event, high for exactly one cycle.
- `hlf_pulse`  out  1  half-frame event, high for exactly one cycle.
- `frame_irq`  out  1  frame interrupt flag, level.
- `mode`  out  1  current sequence mode.
- `step`  out  3  current step index, 0..4.

## Operation
- State:
  - `cyc_cnt`, width clog2(STEP).
  - `step`, 3 bits.
  - mode, inhibit and irq flag registers.
  - registered `qtr_pulse` and `hlf_pulse`.
- Step end: `cyc_cnt == STEP-1`. At step end, `cyc_cnt` is set to 0 and `step` advances. Otherwise `cyc_cnt` increments.
- 4-step mode (mode=0): `step` runs 0,1,2,3 and wraps to 0.
  - End of every step: qtr.
  - End of steps 1 and 3: also hlf.
  - End of step 3: sets irq if inhibit=0.
- 5-step mode (mode=1): `step` runs 0,1,2,3,4 and wraps to 0.
  - End of steps 0,1,2,4: qtr.
  - End of steps 1 and 4: also hlf.
  - End of step 3: no event.
  - The irq flag is never set in this mode.
- Write (`wr_en`=1):
  - Latch mode and inhibit.
  - Force `cyc_cnt`=0 and `step`=0.
  - If the written inhibit=1, clear irq.
  - If the written mode=1, assert `qtr_pulse` and `hlf_pulse` in the next cycle (immediate clock).
- `irq_ack` clears irq.
- Simultaneous events:
  - Write coincident with a step end: the write wins and that step end's events are suppressed. The only pulses that cycle come from the 5-step immediate clock.
  - irq set coincident with `irq_ack`: the set wins and `frame_irq` stays 1.
  - Write with inhibit=1 coincident with irq set: clear wins.
- Reset values: `cyc_cnt`=0, `step`=0, mode=0, inhibit=0, `frame_irq`=0, `qtr_pulse`=0, `hlf_pulse`=0.
  - Reset mid-sequence abandons the step immediately.
  - No pulses are emitted due to reset.

## Timing
- All outputs are registered.
- Event latency: a pulse is high during the cycle after the edge on which `cyc_cnt == STEP-1` is observed.
  - From reset release, the first `qtr_pulse` is high after the STEP-th rising edge.
- Period in 4-step mode:
  - `qtr_pulse` every STEP cycles.
  - `hlf_pulse` every 2*STEP cycles.
  - Full sequence is 4*STEP cycles.
- Period in 5-step mode: full sequence is 5*STEP cycles.
- Write latency:
  - `mode` and `step`=0 are visible the cycle after `wr_en`.
  - The immediate 5-step pulses appear in that same cycle.
  - The next regular step end is STEP cycles after the write edge.
- `frame_irq` is visible in the same cycle as the step-3 `qtr_pulse` and `hlf_pulse`.
- `frame_irq` falls the cycle after `irq_ack`.
- Pulses never last more than one cycle. Consecutive pulses require STEP >= 2.

## Structure
- Shared package `apu_pkg` holds:
  - `MODE_4STEP` and `MODE_5STEP` constants.
  - Register bit positions `FC_MODE_BIT` = 7 and `FC_INHIBIT_BIT` = 6.
  - Per-mode 5-bit step event masks: `QTR_MASK_4`=5'b01111, `HLF_MASK_4`=5'b01010, `QTR_MASK_5`=5'b10111, `HLF_MASK_5`=5'b10010.
- Single module with no sub-module. Event decode is a mask lookup indexed by `step`.
- Pulse outputs are intended as clock enables for the channel blocks. The channel blocks are to be migrated from derived clocks to enables on `apu_clk`.

## Test plan
- STEP=4, reset then idle 32 cycles:
  - `qtr_pulse` high after edges 4, 8, 12, 16, …
  - `hlf_pulse` high after edges 8 and 16.
  - `frame_irq` rises after edge 16.
  - `step` cycles 0-3.
- STEP=4, write 8'h80 (5-step):
  - Immediate `qtr_pulse` and `hlf_pulse` next cycle.
  - Over 20 cycles, qtr after 4, 8, 12, 20 and none after 16.
  - hlf after 8 and 20.
  - `frame_irq` stays 0.
- STEP=4, 4-step, `frame_irq`=1, then write 8'h40: irq clears next cycle and is never re-set over 3 sequences.
- STEP=4, `irq_ack` on the same edge the step-3 end sets irq: `frame_irq`=1 afterwards. A later lone `irq_ack` clears it.
- STEP=4, write 8'h00 on the cycle `cyc_cnt`=3 in step 1: no qtr/hlf that cycle, and the next qtr comes 4 cycles after the write.
- STEP=4, deassert `rst_n` asynchronously mid-step 2:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first qtr comes after the 4th edge.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared constants and helpers for the APU frame sequencer.
//   - Sequence mode encoding (4-step / 5-step).
//   - Frame-counter register bit positions.
//   - Per-mode step event masks, one bit per step index 0..4.
//   - Helpers to decode the events ending on a step and the last step of a mode.
package apu_pkg;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

  localparam int unsigned FC_MODE_BIT    = 7;
  localparam int unsigned FC_INHIBIT_BIT = 6;

  localparam logic [4:0] QTR_MASK_4 = 5'b01111;
  localparam logic [4:0] HLF_MASK_4 = 5'b01010;
  localparam logic [4:0] QTR_MASK_5 = 5'b10111;
  localparam logic [4:0] HLF_MASK_5 = 5'b10010;

  typedef struct packed {
    logic qtr;
    logic hlf;
  } step_evt_t;

  // Events raised at the end of step s in mode m. Steps beyond 4 raise nothing.
  function automatic step_evt_t step_events(input seq_mode_e m, input logic [2:0] s);
    step_evt_t evt;
    evt = '0;
    if (s <= 3'd4) begin
      if (m == MODE_5STEP) begin
        evt.qtr = QTR_MASK_5[s];
        evt.hlf = HLF_MASK_5[s];
      end else begin
        evt.qtr = QTR_MASK_4[s];
        evt.hlf = HLF_MASK_4[s];
      end
    end
    return evt;
  endfunction

  function automatic logic [2:0] last_step(input seq_mode_e m);
    return (m == MODE_5STEP) ? 3'd4 : 3'd3;
  endfunction

endpackage

// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame sequencer producing quarter-frame and half-frame
// clock-enable pulses, plus the frame interrupt of the 4-step sequence.
//   apu_clk    APU clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_en      frame-counter register write strobe
//   wr_data    bit7 = mode (1 = 5-step), bit6 = IRQ inhibit, rest ignored
//   irq_ack    status-read strobe, clears frame_irq
//   qtr_pulse  quarter-frame event, one cycle
//   hlf_pulse  half-frame event, one cycle
//   frame_irq  frame interrupt flag (level)
//   mode       current sequence mode
//   step       current step index 0..4
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP = 3729
) (
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       qtr_pulse,
  output logic       hlf_pulse,
  output logic       frame_irq,
  output logic       mode,
  output logic [2:0] step
);

  localparam int unsigned CW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(STEP - 1);

  logic [CW-1:0] cyc_cnt;
  seq_mode_e     mode_q;
  logic          inhibit;
  logic          step_end;
  step_evt_t     evt;
  logic          irq_set;
  logic          wr_mode;
  logic          wr_inhibit;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^wr_data[5:0];
  assign wr_mode        = wr_data[FC_MODE_BIT];
  assign wr_inhibit     = wr_data[FC_INHIBIT_BIT];
  assign mode           = mode_q;

  always_comb begin
    step_end = (cyc_cnt == CYC_LAST);
    evt      = step_events(mode_q, step);
    irq_set  = step_end && (mode_q == MODE_4STEP) && (step == 3'd3) && !inhibit;
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      step      <= '0;
      mode_q    <= MODE_4STEP;
      inhibit   <= 1'b0;
      frame_irq <= 1'b0;
      qtr_pulse <= 1'b0;
      hlf_pulse <= 1'b0;
    end else if (wr_en) begin
      // A write restarts the sequence and swallows any coincident step end;
      // the 5-step immediate clock is the only event it can produce.
      mode_q    <= wr_mode ? MODE_5STEP : MODE_4STEP;
      inhibit   <= wr_inhibit;
      cyc_cnt   <= '0;
      step      <= '0;
      qtr_pulse <= wr_mode;
      hlf_pulse <= wr_mode;
      if (wr_inhibit || irq_ack) begin
        frame_irq <= 1'b0;
      end
    end else begin
      if (step_end) begin
        cyc_cnt   <= '0;
        step      <= (step == last_step(mode_q)) ? 3'd0 : step + 3'd1;
        qtr_pulse <= evt.qtr;
        hlf_pulse <= evt.hlf;
      end else begin
        cyc_cnt   <= cyc_cnt + 1'b1;
        qtr_pulse <= 1'b0;
        hlf_pulse <= 1'b0;
      end
      // Setting beats a coincident acknowledge.
      if (irq_set) begin
        frame_irq <= 1'b1;
      end else if (irq_ack) begin
        frame_irq <= 1'b0;
      end
    end
  end

endmodule
